// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction field positions, opcodes and fetch FSM states.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int OP_W    = OP_MSB - OP_LSB + 1;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [OP_W-1:0] R_TYPE = 6'h00;
  localparam logic [OP_W-1:0] ADDI   = 6'h08;
  localparam logic [OP_W-1:0] ANDI   = 6'h0C;
  localparam logic [OP_W-1:0] ORI    = 6'h0D;
  localparam logic [OP_W-1:0] SLTI   = 6'h0A;
  localparam logic [OP_W-1:0] LW     = 6'h23;
  localparam logic [OP_W-1:0] SW     = 6'h2B;
  localparam logic [OP_W-1:0] BEQ    = 6'h04;

  // FETCH: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
  typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction
endpackage

// File: rtl/instr_skid_queue.sv
// Two-entry shift queue of {instr, pc_plus4}; slot 0 is always the head so outputs come straight from flops.
// Flush beats push; a push alongside a pop on a full queue is accepted.
module instr_skid_queue
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc_plus4,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc_plus4,
  output logic [1:0]         count
);
  logic [INSTR_W-1:0] instr_q [2];
  logic [ADDR_W-1:0]  pc_q    [2];
  logic               do_pop;
  logic               do_push;
  logic [1:0]         after_pop;

  assign do_pop        = pop && (count != 2'd0);
  assign after_pop     = count - {1'b0, do_pop};
  assign do_push       = push && (after_pop != 2'd2);
  assign head_instr    = instr_q[0];
  assign head_pc_plus4 = pc_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (do_pop) begin
        instr_q[0] <= instr_q[1];
        pc_q[0]    <= pc_q[1];
      end
      // New entry lands in the first free slot after the shift
      if (do_push) begin
        if (after_pop == 2'd0) begin
          instr_q[0] <= push_instr;
          pc_q[0]    <= push_pc_plus4;
        end else begin
          instr_q[1] <= push_instr;
          pc_q[1]    <= push_pc_plus4;
        end
      end
      count <= after_pop + {1'b0, do_push};
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, issues one outstanding word request, buffers up to two returned instructions.
// Request is combinational from state/credit; if_* are registered; stall holds the head, branch flushes and redirects.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [OP_W-1:0]    if_op,
  output logic [ADDR_W-1:0]  if_pc_plus4
);
  fetch_state_t state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        q_count;
  logic [2:0]        credit_used;
  logic              outstanding;
  logic              pop;
  logic              push;
  logic              req_fire;

  assign outstanding = (state != FETCH);
  assign if_valid    = (q_count != 2'd0);
  assign pop         = if_valid && !stall;
  assign credit_used = {1'b0, q_count} + {2'b00, outstanding} - {2'b00, pop};

  // A response in WAIT frees the outstanding slot, so a follow-on request may issue that same cycle
  assign imem_req_valid = rst_n && !branch_taken && (credit_used < 3'd2) &&
                          ((state == FETCH) || ((state == WAIT) && imem_rsp_valid));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // pc already advanced past the outstanding request, so it equals that request's address + 4
  assign push = (state == WAIT) && imem_rsp_valid && !branch_taken;

  instr_skid_queue #(.ADDR_W(ADDR_W)) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push),
    .pop           (pop),
    .flush         (branch_taken),
    .push_instr    (imem_rsp_data),
    .push_pc_plus4 (pc),
    .head_instr    (if_instr),
    .head_pc_plus4 (if_pc_plus4),
    .count         (q_count)
  );

  assign if_op = opcode_of(if_instr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else if (branch_taken) begin
      pc    <= branch_target & ~ADDR_W'(3);
      state <= (outstanding && !imem_rsp_valid) ? DROP : FETCH;
    end else begin
      if (req_fire) pc <= pc + ADDR_W'(4);
      case (state)
        FETCH:   if (req_fire) state <= WAIT;
        WAIT:    if (imem_rsp_valid && !req_fire) state <= FETCH;
        DROP:    if (imem_rsp_valid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory responder with programmable latency, queue-based reference model.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall, branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_op;
  logic [31:0] if_pc_plus4;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_op          (if_op),
    .if_pc_plus4    (if_pc_plus4)
  );

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int rsp_lat = 1;

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] instr; logic [31:0] pcp4;} ent_t;
  pend_t pend[$];
  ent_t  exp_q[$];
  logic [31:0] m_pc, m_out_addr;
  bit m_outst, m_killed;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[7:2] ^ 6'h23, a[25:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory: a response is due rsp_lat cycles after acceptance
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic step();
    tick();
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return imem_req_valid && imem_req_ready;
      1:       return if_valid;
      2:       return imem_req_valid;
      default: return imem_rsp_valid && if_valid;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cond(sel)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    ntests++;
    if (!ok) begin
      nfail++;
      $display("FAIL timeout_%s: condition not seen in 30 cycles, required seen", name);
    end
  endtask

  // Reference model: every cycle, compare outputs, then advance the model to the next edge
  always @(negedge clk) begin
    bit pop_m, acc, exp_req;
    int used;
    if (!rst_n) begin
      exp_q.delete();
      m_pc = 32'h0; m_outst = 1'b0; m_killed = 1'b0; m_out_addr = 32'h0;
    end else begin
      pop_m   = (exp_q.size() != 0) && !stall;
      used    = exp_q.size() + int'(m_outst) - int'(pop_m);
      exp_req = !branch_taken && (used < 2) && (!m_outst || (imem_rsp_valid && !m_killed));
      chk("m_req_valid", imem_req_valid, exp_req);
      if (imem_req_valid) chk("m_req_addr", imem_req_addr, m_pc);
      chk("m_if_valid", if_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("m_if_instr", if_instr, exp_q[0].instr);
        chk("m_if_pc_plus4", if_pc_plus4, exp_q[0].pcp4);
        chk("m_if_op", if_op, exp_q[0].instr[31:26]);
      end
      acc = imem_req_valid && imem_req_ready;
      if (acc) pend.push_back('{imem_req_addr, cyc + rsp_lat});
      if (branch_taken) begin
        exp_q.delete();
        m_pc = branch_target & ~32'h3;
        if (m_outst && !imem_rsp_valid) m_killed = 1'b1;
        else begin m_outst = 1'b0; m_killed = 1'b0; end
      end else begin
        if (pop_m) void'(exp_q.pop_front());
        if (imem_rsp_valid && m_outst) begin
          if (!m_killed) exp_q.push_back('{mem_word(m_out_addr), m_out_addr + 32'd4});
          m_outst = 1'b0; m_killed = 1'b0;
        end
        if (acc) begin
          m_outst = 1'b1; m_killed = 1'b0; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
        end
      end
      if (exp_q.size() > 2) begin
        ntests++; nfail++;
        $display("FAIL m_occupancy: got %0d buffered, expected at most 2", exp_q.size());
      end
    end
  end

  initial begin
    #100000;
    nfail++;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    logic [31:0] hold;
    rst_n = 1'b0; imem_req_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_op", if_op, 0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);

    // Cold start with single-cycle memory
    rst_n = 1'b1; cyc = 0;
    #1;
    chk("c0_req_valid", imem_req_valid, 1);
    chk("c0_req_addr", imem_req_addr, 32'h0);
    step();
    chk("c1_req_addr", imem_req_addr, 32'h4);
    chk("c1_if_valid", if_valid, 0);
    step();
    chk("c2_if_valid", if_valid, 1);
    chk("c2_if_op", if_op, 6'b001000);
    chk("c2_if_instr", if_instr, 32'h2008_0005);
    chk("c2_if_pc_plus4", if_pc_plus4, 32'h4);
    chk("c2_req_addr", imem_req_addr, 32'h8);
    repeat (4) step();

    // Stall for three cycles
    stall = 1'b1;
    #1;
    hold = if_instr;
    chk("stall0_req_valid", imem_req_valid, 0);
    for (int i = 1; i < 3; i++) begin
      step();
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_if_instr", if_instr, hold);
    end
    step();
    stall = 1'b0;
    repeat (6) step();

    // Branch while a request is outstanding, two-cycle memory
    rsp_lat = 2;
    repeat (4) step();
    wait_for("accept_before_branch", 0);
    step();
    branch_taken = 1'b1; branch_target = 32'h42;
    #1;
    chk("br_req_valid", imem_req_valid, 0);
    step();
    branch_taken = 1'b0;
    #1;
    chk("drop_if_valid", if_valid, 0);
    chk("drop_req_valid", imem_req_valid, 0);
    step();
    chk("redirect_req_valid", imem_req_valid, 1);
    chk("redirect_req_addr", imem_req_addr, 32'h40);
    wait_for("target_delivered", 1);
    chk("target_pc_plus4", if_pc_plus4, 32'h44);
    chk("target_instr", if_instr, 32'hCC00_0040);
    repeat (4) step();

    // Branch in the same cycle as a response, with the queue holding an entry
    rsp_lat = 1;
    repeat (5) step();
    wait_for("rsp_with_queue", 3);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    #1;
    chk("brrsp_if_valid", if_valid, 0);
    chk("brrsp_req_valid", imem_req_valid, 1);
    chk("brrsp_req_addr", imem_req_addr, 32'h100);
    step();
    step();
    chk("brrsp_delivered_valid", if_valid, 1);
    chk("brrsp_pc_plus4", if_pc_plus4, 32'h104);
    repeat (3) step();

    // Memory not ready for four cycles
    imem_req_ready = 1'b0;
    #1;
    hold = imem_req_addr;
    for (int i = 0; i < 4; i++) begin
      chk("notready_addr_stable", imem_req_addr, hold);
      if (i < 3) step();
    end
    chk("notready_drained", if_valid, 0);
    step();
    imem_req_ready = 1'b1;
    repeat (4) step();

    // PC wrap at the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    #1;
    wait_for("wrap_req", 2);
    chk("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    wait_for("wrap_second_req", 2);
    chk("wrap_second_addr", imem_req_addr, 32'h0);
    wait_for("wrap_delivered", 1);
    chk("wrap_pc_plus4", if_pc_plus4, 32'h0);
    repeat (3) step();

    // Asynchronous reset with a request outstanding and the queue occupied
    rsp_lat = 3;
    repeat (2) step();
    wait_for("accept_before_reset", 0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    pend.delete();
    imem_rsp_valid = 1'b0;
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_req_addr", imem_req_addr, 32'h0);
    chk("arst_if_valid", if_valid, 0);
    chk("arst_if_instr", if_instr, 32'h0);
    chk("arst_if_op", if_op, 0);
    chk("arst_if_pc_plus4", if_pc_plus4, 32'h0);
    rsp_lat = 1;
    tick();
    tick();
    rst_n = 1'b1; cyc = 0;
    #1;
    chk("rerelease_req_valid", imem_req_valid, 1);
    chk("rerelease_req_addr", imem_req_addr, 32'h0);
    repeat (2) step();
    chk("rerelease_if_instr", if_instr, 32'h2008_0005);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
